// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, FSM states,
// FunSel/mux/register-select codes and the packed control word.
package control_pkg;

    typedef enum logic [2:0] {
        FETCH_L = 3'd0,
        FETCH_H = 3'd1,
        EXEC    = 3'd2,
        EXEC2   = 3'd3,
        HALT    = 3'd4
    } stateT;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_MOVI = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_BRA  = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    localparam logic [1:0] FUN_DEC   = 2'b00;
    localparam logic [1:0] FUN_INC   = 2'b01;
    localparam logic [1:0] FUN_LOAD  = 2'b10;
    localparam logic [1:0] FUN_CLEAR = 2'b11;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;
    localparam logic [1:0] MUX_ARFC = 2'b11;

    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_AR = 2'b01;
    localparam logic [1:0] ARF_SP = 2'b10;

    localparam logic [3:0] REG_NONE = 4'b0000;
    localparam logic [3:0] REG_PC   = 4'b1000;
    localparam logic [3:0] REG_AR   = 4'b0100;
    localparam logic [3:0] REG_SP   = 4'b0010;
    localparam logic [3:0] REG_ALL  = 4'b1110;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0100;

    typedef struct packed {
        logic [2:0] rfOutASel;
        logic [2:0] rfOutBSel;
        logic [1:0] rfFunSel;
        logic [3:0] rfRSel;
        logic [3:0] rfTSel;
        logic [3:0] aluFunSel;
        logic [1:0] arfOutCSel;
        logic [1:0] arfOutDSel;
        logic [1:0] arfFunSel;
        logic [3:0] arfRegSel;
        logic       irLH;
        logic       irEnable;
        logic [1:0] irFunsel;
        logic       memWR;
        logic       memCS;
        logic [1:0] muxASel;
        logic [1:0] muxBSel;
        logic       muxCSel;
    } ctrlWordT;

    // R1..R4 map to RSel 1000..0001.
    function automatic logic [3:0] rxOneHot(input logic [1:0] rx);
        return 4'b1000 >> rx;
    endfunction

    function automatic logic [2:0] rfOutSel(input logic [1:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between control_unit (master) and the datapath (slave).
interface control_unit_if;

    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;

    modport master (
        input  IROut, ALUOutFlag,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
               ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
               ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );

endinterface

// File: rtl/control_unit_seq_counter.sv
// 3-bit T-state sequence counter; clear has priority over increment.
module seq_counter (
    input  logic       Clock,
    input  logic       clear,
    input  logic       inc,
    output logic [2:0] count
);

    always_ff @(posedge Clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch (two byte halves), execute and optional
// memory cycle, with an absorbing HALT state.
module control_unit
    import control_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    control_unit_if.master bus,
    output logic [2:0]     SC,
    output logic           Halted
);

    stateT      state;
    stateT      nextState;
    ctrlWordT   cw;
    logic [3:0] opcode;
    logic [1:0] rx;
    logic [1:0] rsrc;
    logic       zFlag;

    assign opcode = bus.IROut[15:12];
    assign rx     = bus.IROut[11:10];
    assign rsrc   = bus.IROut[9:8];
    assign zFlag  = bus.ALUOutFlag[3];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FETCH_L;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        cw        = '0;
        cw.memCS  = 1'b1;

        unique case (state)
            FETCH_L, FETCH_H: begin
                cw.arfOutDSel = ARF_PC;
                cw.memCS      = 1'b0;
                cw.irEnable   = 1'b1;
                cw.irLH       = (state == FETCH_H);
                cw.irFunsel   = FUN_LOAD;
                cw.arfRegSel  = REG_PC;
                cw.arfFunSel  = FUN_INC;
                nextState     = (state == FETCH_L) ? FETCH_H : EXEC;
            end

            EXEC: begin
                nextState = FETCH_L;
                case (opcode)
                    OP_LD, OP_ST: begin
                        cw.muxBSel   = MUX_IMM;
                        cw.arfRegSel = REG_AR;
                        cw.arfFunSel = FUN_LOAD;
                        nextState    = EXEC2;
                    end
                    OP_MOVI: begin
                        cw.muxASel  = MUX_IMM;
                        cw.rfFunSel = FUN_LOAD;
                        cw.rfRSel   = rxOneHot(rx);
                    end
                    OP_ADD: begin
                        cw.rfOutASel = rfOutSel(rx);
                        cw.rfOutBSel = rfOutSel(rsrc);
                        cw.aluFunSel = ALU_ADD;
                        cw.muxASel   = MUX_ALU;
                        cw.rfFunSel  = FUN_LOAD;
                        cw.rfRSel    = rxOneHot(rx);
                    end
                    OP_BRA, OP_BEQ: begin
                        // BEQ falls through as a plain branch when Z is set.
                        if (opcode == OP_BRA || zFlag) begin
                            cw.muxBSel   = MUX_IMM;
                            cw.arfRegSel = REG_PC;
                            cw.arfFunSel = FUN_LOAD;
                        end
                    end
                    OP_INC: begin
                        cw.rfFunSel = FUN_INC;
                        cw.rfRSel   = rxOneHot(rx);
                    end
                    OP_HALT: begin
                        nextState = HALT;
                    end
                    default: begin
                    end
                endcase
            end

            EXEC2: begin
                nextState     = FETCH_L;
                cw.arfOutDSel = ARF_AR;
                cw.memCS      = 1'b0;
                if (opcode == OP_LD) begin
                    cw.muxASel  = MUX_MEM;
                    cw.rfFunSel = FUN_LOAD;
                    cw.rfRSel   = rxOneHot(rx);
                end else begin
                    cw.rfOutASel = rfOutSel(rx);
                    cw.aluFunSel = ALU_PASS_A;
                    cw.memWR     = 1'b1;
                end
            end

            HALT: begin
                nextState = HALT;
            end

            default: begin
                nextState = FETCH_L;
            end
        endcase

        // Reset overrides whatever the current state asked for, so an
        // in-flight store can never write while Reset is high.
        if (Reset) begin
            cw           = '0;
            cw.memCS     = 1'b1;
            cw.rfFunSel  = FUN_CLEAR;
            cw.rfRSel    = '1;
            cw.rfTSel    = '1;
            cw.arfFunSel = FUN_CLEAR;
            cw.arfRegSel = REG_ALL;
        end
    end

    assign Halted = (state == HALT) && !Reset;

    seq_counter seqCounter (
        .Clock (Clock),
        .clear (Reset || (nextState == FETCH_L)),
        .inc   (state != HALT),
        .count (SC)
    );

    assign bus.RF_OutASel  = cw.rfOutASel;
    assign bus.RF_OutBSel  = cw.rfOutBSel;
    assign bus.RF_FunSel   = cw.rfFunSel;
    assign bus.RF_RSel     = cw.rfRSel;
    assign bus.RF_TSel     = cw.rfTSel;
    assign bus.ALU_FunSel  = cw.aluFunSel;
    assign bus.ARF_OutCSel = cw.arfOutCSel;
    assign bus.ARF_OutDSel = cw.arfOutDSel;
    assign bus.ARF_FunSel  = cw.arfFunSel;
    assign bus.ARF_RegSel  = cw.arfRegSel;
    assign bus.IR_LH       = cw.irLH;
    assign bus.IR_Enable   = cw.irEnable;
    assign bus.IR_Funsel   = cw.irFunsel;
    assign bus.Mem_WR      = cw.memWR;
    assign bus.Mem_CS      = cw.memCS;
    assign bus.MuxASel     = cw.muxASel;
    assign bus.MuxBSel     = cw.muxBSel;
    assign bus.MuxCSel     = cw.muxCSel;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 IROut  in  16  instruction register contents from datapath.
REQ-004 ALUOutFlag  in  4  {Z,C,N,O}; Z = bit 3.
REQ-005 RF_OutASel, RF_OutBSel  out  3 each  RF read selects; RF_FunSel out 2; RF_RSel, RF_TSel out 4 each, active-high enables.
REQ-006 ALU_FunSel  out  4  ALU operation.
REQ-007 ARF_OutCSel, ARF_OutDSel, ARF_FunSel  out  2 each; ARF_RegSel out 4, bit3=PC, bit2=AR, bit1=SP, bit0 unused, active-high.
REQ-008 IR_LH, IR_Enable out 1; IR_Funsel out 2; Mem_WR out 1 (1=write); Mem_CS out 1 (0=selected).
REQ-009 MuxASel, MuxBSel  out  2 each (00 ALU, 01 Mem, 10 IR[7:0], 11 ARF OutC); MuxCSel out 1.
REQ-010 SC  out  3  sequence counter T-state; Halted  out  1  high in HALT.

Function
REQ-011 FunSel encoding for RF/ARF/IR SHALL be 00 decrement, 01 increment, 10 load, 11 clear.
REQ-012 Instruction fields: [15:12] opcode, [11:10] Rx (R1..R4 -> one-hot RSel 1000..0001), [9:8] Rsrc, [7:0] address/immediate.
REQ-013 Opcodes: 0 LD Rx<=M[addr]; 1 ST M[addr]<=Rx; 2 MOVI Rx<=imm; 3 ADD Rx<=Rx+Rsrc; 4 BRA PC<=addr; 5 BEQ if Z PC<=addr; 6 INC Rx<=Rx+1; 7 HALT; 8-15 NOP.
REQ-014 States: FETCH_L (SC=0), FETCH_H (SC=1), EXEC (SC=2), EXEC2 (SC=3), HALT.
REQ-015 FETCH_L: OutDSel=PC, Mem_CS=0, Mem_WR=0, IR_Enable=1, IR_LH=0, IR_Funsel=10, PC increment; next FETCH_H.
REQ-016 FETCH_H: same with IR_LH=1; next EXEC.
REQ-017 EXEC single-cycle ops (MOVI, ADD, BRA, BEQ, INC, NOP) SHALL complete in EXEC and return to FETCH_L; instruction latency 3 cycles.
REQ-018 LD/ST: EXEC loads AR from IR[7:0] via MuxB=10; EXEC2 drives OutDSel=AR and performs memory read into Rx (MuxA=01) or write of Rx via ALU pass-through (Mem_WR=1); latency 4 cycles.
REQ-019 BEQ SHALL sample ALUOutFlag[3] combinationally in EXEC; Z=0 leaves PC unchanged.
REQ-020 HALT opcode SHALL enter HALT; HALT is absorbing until Reset; all enables low.
REQ-021 Outputs SHALL be combinational from state and IROut; in any state, unused enables (RSel, TSel, RegSel, IR_Enable) = 0, Mem_CS=1, Mem_WR=0.
REQ-022 SC SHALL increment per cycle and clear to 0 on every return to FETCH_L; it never exceeds 3.
REQ-023 Only one register file write target SHALL be enabled per cycle; memory write and IR load never coincide.

Reset
REQ-024 While Reset=1: state<=FETCH_L, SC<=0, outputs drive clear (FunSel 11) to all RF (RSel=1111, TSel=1111) and ARF (RegSel=1110) registers, Mem_CS=1, Halted=0.
REQ-025 Reset asserted mid-instruction (any state, including HALT) SHALL abort it; first fetch occurs the cycle after Reset falls, from PC=0.

Structure
REQ-026 Shared package control_pkg SHALL hold opcode constants, state enum, FunSel/mux/select encodings.
REQ-027 One sub-module, seq_counter (3-bit, synchronous clear/increment), SHALL be instantiated.
REQ-028 control_unit plus ALU_System SHALL form the top-level CPU; no datapath logic inside control_unit.

Verification
REQ-029 Reset held 2 cycles, released -> SC=0, FETCH_L outputs: OutDSel=PC, IR_Enable=1, IR_LH=0, Mem_CS=0.
REQ-030 IROut=16'h2405 (MOVI R2,5) in EXEC -> MuxASel=10, RF_FunSel=10, RF_RSel=0100; SC returns 0 next cycle.
REQ-031 IROut=16'h0C20 (LD R4,20h) -> EXEC: MuxBSel=10, RegSel=0100; EXEC2: OutDSel=AR, MuxASel=01, RF_RSel=0001; 4-cycle latency.
REQ-032 IROut=16'h5033 with Z=0 -> ARF_RegSel=0000 in EXEC; with Z=1 -> RegSel=1000, FunSel=10, MuxBSel=10.
REQ-033 IROut=16'h7000 -> Halted=1, all enables 0 for 10 cycles; Reset -> FETCH_L next cycle.
REQ-034 Reset asserted in EXEC2 of ST -> Mem_WR=0 that cycle; fetch restarts.
